// File: rtl/multi_motor_ctl.sv
// N-channel closed-loop motor drive: per-channel distance countdown, per-window duty regulation, abort.
// Optional stall detection is compiled in with `define STALL_DET_EN.

module multi_motor_ctl_ch #(
  parameter int CNT_W     = 16,
  parameter int RATE_W    = 12,
  parameter int PWM_W     = 8,
  parameter int DUTY_INIT = 128,
  parameter int DUTY_STEP = 4
`ifdef STALL_DET_EN
  , parameter int STALL_WIN = 8
`endif
) (
  input  logic              WF_CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              encdr,
  input  logic [CNT_W-1:0]  target_cnt,
  input  logic [RATE_W-1:0] target_rate,
  input  logic              win_end,
  input  logic [PWM_W-1:0]  pwm_cnt,
  output logic              accept,
  output logic              pwm,
  output logic              en,
  output logic              done,
  output logic              bumped,
  output logic              stall
);
  localparam logic [PWM_W-1:0] DMAX  = '1;
  localparam logic [PWM_W-1:0] DINIT = PWM_W'(DUTY_INIT);
  localparam logic [PWM_W-1:0] DSTEP = PWM_W'(DUTY_STEP);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [2:0]        enc_pipe;
  logic              rise, last_edge, stall_hit;
  logic              set_done, set_bump;
  logic [CNT_W-1:0]  remaining;
  logic [RATE_W-1:0] win_edges;
  logic [PWM_W-1:0]  duty, duty_adj;

  // [0],[1] synchronise the pin, [2] holds the previous synchronised level
  always_ff @(posedge WF_CLK or negedge rst_n)
    if (!rst_n) enc_pipe <= '0;
    else        enc_pipe <= {enc_pipe[1:0], encdr};

  assign rise      = enc_pipe[1] & ~enc_pipe[2];
  assign last_edge = rise && (remaining == CNT_W'(1));
  assign accept    = (state == IDLE) && start && !abort && (target_cnt != '0);
  assign en        = (state == RUN);
  assign pwm       = en && (pwm_cnt < duty);

`ifdef STALL_DET_EN
  localparam int SC_W = $clog2(STALL_WIN + 1);
  logic [SC_W-1:0] stall_cnt;
  logic            starved;

  assign starved   = win_end && en && (win_edges == '0) && (duty == DMAX) && !rise;
  assign stall_hit = starved && (stall_cnt == SC_W'(STALL_WIN - 1));

  always_ff @(posedge WF_CLK or negedge rst_n)
    if (!rst_n)              stall_cnt <= '0;
    else if (accept || rise) stall_cnt <= '0;
    else if (starved)        stall_cnt <= stall_cnt + SC_W'(1);

  // abort takes priority, so a stall coinciding with abort is reported as a bump only
  always_ff @(posedge WF_CLK or negedge rst_n)
    if (!rst_n)                      stall <= 1'b0;
    else if (accept)                 stall <= 1'b0;
    else if (stall_hit && !abort)    stall <= 1'b1;
`else
  assign stall_hit = 1'b0;
  assign stall     = 1'b0;
`endif

  always_ff @(posedge WF_CLK or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    set_done  = 1'b0;
    set_bump  = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (abort)                  set_bump  = 1'b1;
        else if (target_cnt == '0)  set_done  = 1'b1;
        else                        state_nxt = RUN;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          set_bump  = 1'b1;
        end else if (last_edge) begin
          state_nxt = IDLE;
          set_done  = 1'b1;
        end else if (stall_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    duty_adj = duty;
    if (win_edges < target_rate)      duty_adj = (duty > DMAX - DSTEP) ? DMAX : duty + DSTEP;
    else if (win_edges > target_rate) duty_adj = (duty < DSTEP) ? '0 : duty - DSTEP;
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      duty      <= DINIT;
      win_edges <= '0;
      done      <= 1'b0;
      bumped    <= 1'b0;
    end else begin
      done <= set_done;
      if (accept) begin
        remaining <= target_cnt;
        duty      <= DINIT;
        win_edges <= '0;
        bumped    <= 1'b0;
      end else begin
        if (set_bump) bumped <= 1'b1;
        if (en && rise) remaining <= remaining - CNT_W'(1);
        // an edge landing on the window's last clock belongs to the next window
        if (win_end) begin
          if (en) duty <= duty_adj;
          win_edges <= RATE_W'(rise);
        end else if (rise && (win_edges != '1)) begin
          win_edges <= win_edges + RATE_W'(1);
        end
      end
    end
  end
endmodule

module multi_motor_ctl #(
  parameter int NCH       = 2,
  parameter int CNT_W     = 16,
  parameter int RATE_W    = 12,
  parameter int PWM_W     = 8,
  parameter int WIN_CYC   = 480000,
  parameter int DUTY_INIT = 128,
  parameter int DUTY_STEP = 4,
  parameter int STALL_WIN = 8
) (
  input  logic                  WF_CLK,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NCH-1:0]        abort,
  input  logic [NCH-1:0]        encdr,
  input  logic [NCH*CNT_W-1:0]  target_cnt,
  input  logic [NCH*RATE_W-1:0] target_rate,
  output logic [NCH-1:0]        pwm,
  output logic [NCH-1:0]        en,
  output logic [NCH-1:0]        done,
  output logic [NCH-1:0]        bumped,
  output logic [NCH-1:0]        stall,
  output logic                  busy
);
  localparam int WIN_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);

  logic [PWM_W-1:0] pwm_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic             win_end;
  logic [NCH-1:0]   accept;

  assign win_end = (win_cnt == WIN_LAST);
  assign busy    = |en;

  always_ff @(posedge WF_CLK or negedge rst_n)
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_W'(1);

  // window phase is re-aligned whenever any channel starts a move
  always_ff @(posedge WF_CLK or negedge rst_n)
    if (!rst_n)                  win_cnt <= '0;
    else if (|accept || win_end) win_cnt <= '0;
    else                         win_cnt <= win_cnt + WIN_W'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    multi_motor_ctl_ch #(
      .CNT_W(CNT_W), .RATE_W(RATE_W), .PWM_W(PWM_W),
      .DUTY_INIT(DUTY_INIT), .DUTY_STEP(DUTY_STEP)
`ifdef STALL_DET_EN
      , .STALL_WIN(STALL_WIN)
`endif
    ) u_ch (
      .WF_CLK     (WF_CLK),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort[i]),
      .encdr      (encdr[i]),
      .target_cnt (target_cnt[i*CNT_W +: CNT_W]),
      .target_rate(target_rate[i*RATE_W +: RATE_W]),
      .win_end    (win_end),
      .pwm_cnt    (pwm_cnt),
      .accept     (accept[i]),
      .pwm        (pwm[i]),
      .en         (en[i]),
      .done       (done[i]),
      .bumped     (bumped[i]),
      .stall      (stall[i])
    );
  end
endmodule

// File: doc/multi_motor_ctl.md
Name: multi_motor_ctl

Overview:
Parametrised N-channel closed-loop motor drive controller; the next generation of the single-channel fixed-speed step controller. Each channel runs its motor for a commanded number of encoder edges. Duty is regulated per measurement window toward a commanded edge rate, and a per-channel abort input (bumper) stops the channel immediately. Sits between the button edge detector and bump inputs and the motor driver pins at the top level.

Parameters:
NCH, 2, number of motor channels
CNT_W, 16, width of distance (encoder edge) counters
RATE_W, 12, width of rate target / per-window edge counter
PWM_W, 8, PWM resolution; period = 2^PWM_W clocks
WIN_CYC, 480000, clocks per speed-measurement window (10 ms at 48 MHz)
DUTY_INIT, 128, duty loaded at start
DUTY_STEP, 4, duty adjustment per window
STALL_WIN, 8, windows of zero edges at full duty before stall (STALL_DET_EN only)

Ports:
WF_CLK  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  single-cycle start pulse for all idle channels
abort  in  NCH  per-channel stop request, level, active-high
encdr  in  NCH  raw encoder inputs (asynchronous)
target_cnt  in  NCH*CNT_W  edges to travel; channel i at [i*CNT_W +: CNT_W]; sampled on start
target_rate  in  NCH*RATE_W  desired edges per window; sampled every window end
pwm  out  NCH  PWM drive
en  out  NCH  driver enable; high only in RUN
done  out  NCH  one-cycle pulse when target reached
bumped  out  NCH  sticky: channel was aborted; cleared by next accepted start
stall  out  NCH  sticky stall flag (0 unless STALL_DET_EN)
busy  out  1  OR of en

Behaviour:
- Reset: all outputs 0, all channels IDLE, counters 0, duty = DUTY_INIT, PWM and window counters 0.
- encdr: 2-flop synchroniser plus edge register per channel; one rising edge = one count. Latency from pin edge to count: 3 clocks.
- Per-channel FSM, IDLE/RUN:
  - IDLE->RUN on start when abort=0 and target_cnt!=0. Load remaining = target_cnt and duty = DUTY_INIT. Clear bumped and stall. en=1 next cycle.
  - start with target_cnt=0: stay IDLE, done pulses the next cycle.
  - start with abort=1: stay IDLE, bumped=1 next cycle.
  - start while in RUN: ignored for that channel.
  - In RUN, each counted edge decrements remaining. When remaining reaches 0: ->IDLE, en=0 and done=1 on the same following cycle.
  - abort=1 in RUN: ->IDLE next cycle, en=0, bumped=1, no done. Abort wins over a simultaneous final edge.
- PWM: one free-running PWM_W counter shared by all channels; pwm[i] = en[i] & (pwm_cnt < duty[i]). Duty 0 gives constant low. Max duty 2^PWM_W-1 gives high for all but one clock per period.
- Window: free-running counter 0..WIN_CYC-1, shared, restarted by an accepted start. At the last count, for each RUN channel:
  - win_edges < target_rate: duty += DUTY_STEP, saturating at 2^PWM_W-1.
  - win_edges > target_rate: duty -= DUTY_STEP, saturating at 0.
  - equal: hold.
  - win_edges is then cleared. An edge in that same cycle counts toward the new window.
- win_edges saturates at 2^RATE_W-1. Distance counter never wraps, because RUN exits at 0.
- rst_n low mid-run: en and pwm drop asynchronously; all state returns to reset values.

Optional Feature:
STALL_DET_EN:
- Defined: per-channel counter of consecutive windows with win_edges=0 while duty is at max. When it reaches STALL_WIN: ->IDLE, en=0, stall=1 (sticky), no done. Any edge clears the counter.
- Undefined: stall tied to 0, no stall logic; the channel keeps driving indefinitely.

Test Plan:
- NCH=2, WIN_CYC=100, PWM_W=4, DUTY_INIT=8. start with target_cnt=20/30 and 20/30 edges applied -> done pulses after the 20th and 30th counted edges respectively; en falls the same cycle; busy falls after ch1.
- abort[0] raised after 5 edges -> en[0]=0 and bumped[0]=1 next cycle, no done[0]; ch1 unaffected; next start clears bumped[0].
- target_rate=10, 4 edges per window -> duty rises 8->12->15 (saturates); at 20 edges per window duty falls by DUTY_STEP per window to 0; pwm duty cycle checked against duty.
- start with target_cnt=0 -> done pulse, en stays 0. start with abort high -> bumped=1, en stays 0. Second start mid-run -> ignored, remaining unchanged.
- rst_n asserted mid-run -> en, pwm, done, bumped, busy 0 immediately.
- STALL_DET_EN, STALL_WIN=3, no edges -> duty reaches max, then after 3 zero-edge windows stall=1 and en=0. Without the macro, en stays 1.
